// File: rtl/inst_fetch_if_pkg.sv
// Shared types and constants for the instruction-fetch responder.
// Holds the fetch FSM state encoding and the architectural reset PC.
// No logic; imported by inst_fetch_if and ifetch_skid_buf.
package inst_fetch_if_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        REQ     = 3'd1,
        WAIT    = 3'd2,
        HOLD    = 3'd3,
        DISCARD = 3'd4
    } ifetch_state_t;

    localparam logic [31:0] RESET_PC = 32'hbfc00000;
    localparam logic [31:0] NOP_INST = 32'h0;

endpackage

// File: rtl/ifetch_skid_buf.sv
// Single-entry instruction/PC buffer that parks a response while ID is stalled.
// Latency: load visible on buf_vld/buf_dat/buf_pc the cycle after the load edge.
// Backpressure: none of its own; the owner FSM only loads when the entry is free.
// Ports: clk_i/rst_i (async active-high), load + wr_dat/wr_pc, clear,
//        buf_vld/buf_dat/buf_pc outputs.
module ifetch_skid_buf
    import inst_fetch_if_pkg::*;
(
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load,
    input  logic        clear,
    input  logic [31:0] wr_dat,
    input  logic [31:0] wr_pc,
    output logic        buf_vld,
    output logic [31:0] buf_dat,
    output logic [31:0] buf_pc
);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            buf_vld <= 1'b0;
            buf_dat <= NOP_INST;
            buf_pc  <= RESET_PC;
        end else if (clear) begin
            buf_vld <= 1'b0;
        end else if (load) begin
            buf_vld <= 1'b1;
            buf_dat <= wr_dat;
            buf_pc  <= wr_pc;
        end
    end

endmodule

// File: rtl/inst_fetch_if.sv
// IF-stage fetch responder: one SRAM-like req/addr_ok/data_ok transaction per PC.
// Latency: zero-wait memory delivers in cycle 2 after sampling pc_i, outputs valid in cycle 3.
// Backpressure: stall_i holds the output registers (response parked in a skid buffer);
//               stall_o holds the PC register until the current PC is delivered.
// Ports: clk_i/rst_i, pc_i/ce_i from PC, flush_i/stall_i from pipeline control,
//        inst_req_o/inst_addr_o/inst_addr_ok_i/inst_data_ok_i/inst_rdata_i to memory,
//        inst_o/inst_pc_o/inst_valid_o/stall_o to IF/ID and PC.
// Optional: IFETCH_ADDR_CHECK_EN adds misaligned-PC detection and the inst_adel_o port.
module inst_fetch_if
    import inst_fetch_if_pkg::*;
#(
    parameter logic [31:0] RESET_ADDR = RESET_PC
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic [31:0] pc_i,
    input  logic        ce_i,
    input  logic        flush_i,
    input  logic        stall_i,
    output logic        inst_req_o,
    output logic [31:0] inst_addr_o,
    input  logic        inst_addr_ok_i,
    input  logic        inst_data_ok_i,
    input  logic [31:0] inst_rdata_i,
    output logic [31:0] inst_o,
    output logic [31:0] inst_pc_o,
    output logic        inst_valid_o,
    output logic        stall_o
`ifdef IFETCH_ADDR_CHECK_EN
    ,
    output logic        inst_adel_o
`endif
);

    ifetch_state_t state, state_nxt;
    logic          flush_pend, flush_pend_nxt;
    logic          can_out;
    logic          rsp_avail;
    logic          deliver;
    logic          addr_load;
    logic [31:0]   out_dat;
    logic [31:0]   out_pc;
    logic          buf_load;
    logic          buf_clear;
    logic          buf_vld;
    logic [31:0]   buf_dat;
    logic [31:0]   buf_pc;
`ifdef IFETCH_ADDR_CHECK_EN
    logic          adel_hit;
`endif

    assign can_out    = ~inst_valid_o | ~stall_i;
    assign inst_req_o = (state == REQ);
    assign stall_o    = ~deliver;

    always_comb begin
        state_nxt      = state;
        flush_pend_nxt = flush_pend;
        rsp_avail      = 1'b0;
        addr_load      = 1'b0;
        out_dat        = inst_rdata_i;
        out_pc         = inst_addr_o;
        buf_load       = 1'b0;
        buf_clear      = 1'b0;
`ifdef IFETCH_ADDR_CHECK_EN
        adel_hit       = 1'b0;
`endif
        case (state)
            IDLE: begin
                if (ce_i && !flush_i) begin
`ifdef IFETCH_ADDR_CHECK_EN
                    // A misaligned PC never reaches memory; it is answered
                    // locally with a NOP tagged as an address error.
                    if (pc_i[1:0] != 2'b00) begin
                        adel_hit  = 1'b1;
                        rsp_avail = 1'b1;
                        out_dat   = NOP_INST;
                        out_pc    = pc_i;
                    end else begin
                        state_nxt = REQ;
                        addr_load = 1'b1;
                    end
`else
                    state_nxt = REQ;
                    addr_load = 1'b1;
`endif
                end
            end
            REQ: begin
                // The request cannot be withdrawn, so a flush seen before
                // addr_ok is remembered and the response discarded later.
                if (inst_addr_ok_i) begin
                    state_nxt      = (flush_i || flush_pend) ? DISCARD : WAIT;
                    flush_pend_nxt = 1'b0;
                end else if (flush_i) begin
                    flush_pend_nxt = 1'b1;
                end
            end
            WAIT: begin
                if (inst_data_ok_i) begin
                    rsp_avail = 1'b1;
                    if (flush_i || can_out) begin
                        state_nxt = IDLE;
                    end else begin
                        state_nxt = HOLD;
                        buf_load  = 1'b1;
                    end
                end else if (flush_i) begin
                    state_nxt = DISCARD;
                end
            end
            HOLD: begin
                rsp_avail = buf_vld;
                out_dat   = buf_dat;
                out_pc    = buf_pc;
                if (flush_i || can_out) begin
                    state_nxt = IDLE;
                    buf_clear = 1'b1;
                end
            end
            DISCARD: begin
                if (inst_data_ok_i) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
        deliver = rsp_avail && can_out && !flush_i;
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state      <= IDLE;
            flush_pend <= 1'b0;
        end else begin
            state      <= state_nxt;
            flush_pend <= flush_pend_nxt;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inst_addr_o <= RESET_ADDR;
        end else if (addr_load) begin
            inst_addr_o <= pc_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            inst_o       <= NOP_INST;
            inst_pc_o    <= RESET_ADDR;
            inst_valid_o <= 1'b0;
`ifdef IFETCH_ADDR_CHECK_EN
            inst_adel_o  <= 1'b0;
`endif
        end else if (deliver) begin
            inst_o       <= out_dat;
            inst_pc_o    <= out_pc;
            inst_valid_o <= 1'b1;
`ifdef IFETCH_ADDR_CHECK_EN
            inst_adel_o  <= adel_hit;
`endif
        end else if (!stall_i || flush_i) begin
            inst_valid_o <= 1'b0;
`ifdef IFETCH_ADDR_CHECK_EN
            inst_adel_o  <= 1'b0;
`endif
        end
    end

    ifetch_skid_buf u_skid_buf (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .load    (buf_load),
        .clear   (buf_clear),
        .wr_dat  (inst_rdata_i),
        .wr_pc   (inst_addr_o),
        .buf_vld (buf_vld),
        .buf_dat (buf_dat),
        .buf_pc  (buf_pc)
    );

endmodule
